// File: rtl/op_rd_pkg.sv
// Shared types and constants for the output-SRAM readback engine.
package op_rd_pkg;

  localparam int OP_DEPTH   = 340;
  localparam int OP_ADDR_W  = 9;
  localparam int OP_DATA_W  = 128;
  localparam int FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Pointer step for the 3-entry ring; wraps from FIFO_DEPTH-1 back to 0.
  function automatic logic [1:0] fifo_ptr_next(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/op_rd_fifo.sv
// 3-entry synchronous FIFO holding SRAM read data until the consumer takes it.
module op_rd_fifo
  import op_rd_pkg::*;
#(
  parameter int W = OP_DATA_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic [1:0]   r_wr_ptr;
  logic [1:0]   r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_do_pop;

  // The issuing side never pushes into a full FIFO, so only pop needs a guard.
  assign w_do_pop = i_pop && (r_occ != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= fifo_ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= fifo_ptr_next(r_rd_ptr);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/op_sram_reader.sv
// Readback engine: owns the output SRAM after the corelet finishes and
// streams a run of sequential rows out on a valid/ready port.
module op_sram_reader
  import op_rd_pkg::*;
#(
  parameter int ADDR_W = OP_ADDR_W,
  parameter int DATA_W = OP_DATA_W,
  parameter int DEPTH  = OP_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  output logic              cl_sel,
  output logic              op_cen,
  output logic              op_wen,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] DEPTH_M1 = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic              r_inflight;
  logic              r_err;

  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;
  logic [2:0]        w_outstanding;
  logic              w_issue;
  logic              w_pop;

  // Credit: words buffered plus the one being returned by the SRAM. Only
  // registered state is used, so a pop this cycle frees space next cycle.
  assign w_outstanding = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_issue       = (r_state == READ) && (w_outstanding < 3'(FIFO_DEPTH));

  // Output handshake: out_valid means the FIFO head is presented on out_data;
  // a word transfers on any cycle with out_valid && out_ready, and while
  // out_valid && !out_ready the head (and so out_data) cannot change.
  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? w_head : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (base_addr > DEPTH_M1) begin
              r_err <= 1'b1;
            end else if (word_cnt == '0) begin
              r_state <= FIN;
            end else begin
              r_addr      <= base_addr;
              r_remaining <= word_cnt;
              r_state     <= READ;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr      <= (r_addr == DEPTH_M1) ? '0 : r_addr + ONE;
            r_remaining <= r_remaining - ONE;
            if (r_remaining == ONE) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Leave once the last word is on its way out this cycle.
          if (!r_inflight && ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop))) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  op_rd_fifo #(
    .W (DATA_W)
  ) u_fifo (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (r_inflight),
    .i_push_data (op_q),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign busy      = (r_state != IDLE);
  assign cl_sel    = busy;
  assign op_cen    = !w_issue;
  assign op_wen    = 1'b1;
  assign op_addr   = r_addr;
  assign done      = (r_state == FIN);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_op_sram_reader.sv
// Directed bench for op_sram_reader with an SRAM model and an in-order scoreboard.
module tb_op_sram_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [8:0]   base_addr;
  logic [8:0]   word_cnt;
  logic         cl_sel;
  logic         op_cen;
  logic         op_wen;
  logic [8:0]   op_addr;
  logic [127:0] op_q = '0;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [8:0]   addr_q[$];
  int exp_issues, exp_xfers;
  int issued_n, xfer_n, max_out;

  int done_cyc, first_valid, err_cyc, done_count, err_count;
  logic [63:0] cl_hist, busy_hist;
  logic any_cen, any_wen0, prev_stall;
  logic [127:0] prev_data;

  op_sram_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .cl_sel    (cl_sel),
    .op_cen    (op_cen),
    .op_wen    (op_wen),
    .op_addr   (op_addr),
    .op_q      (op_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input int a);
    logic [15:0] v;
    v = 16'(a);
    return {8{v}};
  endfunction

  function automatic logic ready_at(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return ((c % 4) == 0) || ((c % 4) == 3);
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SRAM model: preloaded word i = {8{i[15:0]}}, one-cycle read latency.
  always @(posedge clk) begin
    if (!op_cen && cl_sel) op_q <= word_of(int'(op_addr));
  end

  // Scoreboard: issue addresses and transferred data in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (issued_n - xfer_n > max_out) max_out = issued_n - xfer_n;
      if (!op_cen) begin
        if (addr_q.size() == 0) check("extra_issue", 128'(issued_n + 1), 128'(exp_issues));
        else check("issue_addr", 128'(op_addr), 128'(addr_q.pop_front()));
        issued_n++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_xfer", 128'(xfer_n + 1), 128'(exp_xfers));
        else check("xfer_data", out_data, exp_q.pop_front());
        xfer_n++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 128'({cl_sel, busy, op_cen, op_wen, out_valid, done, err}), 128'(7'b0011000));
    check({tag, "_addr"}, 128'(op_addr), 128'd0);
    check({tag, "_data"}, out_data, 128'd0);
    check({tag, "_state"}, 128'(dbg_state), 128'd0);
  endtask

  // Driver: start at cycle 0, then sample each cycle at the falling edge.
  task automatic run_op(input int base, input int cnt, input int mode,
                        input int rst_cyc, input int restart_cyc, input int limit);
    exp_issues = 0;
    exp_xfers  = 0;
    if (base < 340) begin
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back(word_of((base + i) % 340));
        addr_q.push_back(9'((base + i) % 340));
      end
      exp_issues = cnt;
      exp_xfers  = cnt;
    end
    done_cyc = -1; first_valid = -1; err_cyc = -1; done_count = 0; err_count = 0;
    cl_hist = '0; busy_hist = '0; any_cen = 1'b0; any_wen0 = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    issued_n = 0; xfer_n = 0; max_out = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'(base); word_cnt = 9'(cnt); out_ready = ready_at(mode, 0);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (rst_cyc >= 0 && c == rst_cyc + 1) check_reset_vals("rst_mid");
      if (done) begin done_count++; if (done_cyc < 0) done_cyc = c; end
      if (err) begin err_count++; if (err_cyc < 0) err_cyc = c; end
      if (out_valid && first_valid < 0) first_valid = c;
      if (!op_cen) any_cen = 1'b1;
      if (!op_wen) any_wen0 = 1'b1;
      if (c < 64) begin cl_hist[c] = cl_sel; busy_hist[c] = busy; end
      if (prev_stall) check("stall_hold", {out_valid, out_data[126:0]}, {1'b1, prev_data[126:0]});
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      @(posedge clk); #1;
      start = (c + 1 == restart_cyc);
      if (c + 1 == restart_cyc) begin base_addr = 9'd200; word_cnt = 9'd1; end
      reset = (c + 1 == rst_cyc);
      out_ready = ready_at(mode, c + 1);
    end
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_init");

    // Base 0, cnt 4, ready high
    run_op(0, 4, 0, -1, -1, 20);
    check("t1_first_valid", 128'(first_valid), 128'd3);
    check("t1_done_cyc", 128'(done_cyc), 128'd7);
    check("t1_done_cnt", 128'(done_count), 128'd1);
    check("t1_cl_sel", 128'(cl_hist), 128'h0FE);
    check("t1_busy", 128'(busy_hist), 128'h0FE);
    check("t1_wen", 128'(any_wen0), 128'd0);
    check("t1_left", 128'(exp_q.size() + addr_q.size()), 128'd0);

    // Wrap from 338
    run_op(338, 4, 0, -1, -1, 20);
    check("t2_done_cyc", 128'(done_cyc), 128'd7);
    check("t2_left", 128'(exp_q.size() + addr_q.size()), 128'd0);

    // Throttled consumer
    run_op(20, 8, 1, -1, -1, 60);
    check("t3_max_outst_ok", 128'(max_out <= 3), 128'd1);
    check("t3_done_seen", 128'(done_cyc >= 0), 128'd1);
    check("t3_left", 128'(exp_q.size() + addr_q.size()), 128'd0);

    // Rejected base
    run_op(400, 4, 0, -1, -1, 4);
    check("t4_err_cyc", 128'(err_cyc), 128'd1);
    check("t4_err_cnt", 128'(err_count), 128'd1);
    check("t4_cl_sel", 128'(cl_hist), 128'd0);
    check("t4_cen", 128'(any_cen), 128'd0);
    check("t4_done", 128'(done_count), 128'd0);

    // Zero count
    run_op(5, 0, 0, -1, -1, 10);
    check("t5_done_cyc", 128'(done_cyc), 128'd1);
    check("t5_cl_sel", 128'(cl_hist), 128'h2);
    check("t5_cen", 128'(any_cen), 128'd0);
    check("t5_err", 128'(err_count), 128'd0);

    // Reset in cycle 4 of a cnt-10 run, then a fresh run
    run_op(0, 10, 0, 4, -1, 12);
    check("t6_done", 128'(done_count), 128'd0);
    check("t6_issue_left", 128'(addr_q.size()), 128'd7);
    check("t6_xfer_left", 128'(exp_q.size()), 128'd9);
    addr_q.delete();
    exp_q.delete();
    run_op(100, 3, 0, -1, -1, 20);
    check("t6b_done_cyc", 128'(done_cyc), 128'd6);
    check("t6b_left", 128'(exp_q.size() + addr_q.size()), 128'd0);

    // Second start while reading is ignored
    run_op(10, 6, 0, -1, 3, 30);
    check("t7_done_cyc", 128'(done_cyc), 128'd9);
    check("t7_done_cnt", 128'(done_count), 128'd1);
    check("t7_left", 128'(exp_q.size() + addr_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_sram_reader.md
# op_sram_reader

Readback engine for the 340x128 output SRAM. After the corelet signals `seq_done`, this block takes SRAM ownership through the SRAM-side access select and issues sequential reads of the final output rows. It streams each 128-bit row out on a valid/ready interface toward the host/test side. The corelet writes the output SRAM; this block is the reader on the same SRAM port.

## Interface
- `ADDR_W`, 9, output SRAM address width
- `DATA_W`, 128, output SRAM word width (8 cols x 16-bit psum)
- `DEPTH`, 340, number of valid SRAM words; addresses 0..DEPTH-1
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address, sampled with `start`
- `word_cnt`  in  ADDR_W  number of words to read, sampled with `start`; 0 allowed
- `cl_sel`  out  1  SRAM access select; 1 while this block owns the SRAM
- `op_cen`  out  1  SRAM chip enable, active-low
- `op_wen`  out  1  SRAM write enable, active-low; constant 1 (never writes)
- `op_addr`  out  ADDR_W  SRAM address
- `op_q`  in  DATA_W  SRAM read data, valid the cycle after `op_cen`=0
- `out_data`  out  DATA_W  streamed row
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts; transfer when valid && ready
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse after final transfer
- `err`  out  1  one-cycle pulse: start rejected (base_addr >= DEPTH)

## Operation
- States: IDLE, READ (issuing), DRAIN (all reads issued, FIFO not empty), FIN (one cycle, `done`=1).
- IDLE + `start`:
  - If `base_addr` >= DEPTH: pulse `err` next cycle and stay IDLE.
  - Else if `word_cnt`==0: go to FIN.
  - Else: latch `base_addr`/`word_cnt`, go to READ.
- READ: issue one read per cycle (`op_cen`=0) when `fifo_occ + inflight < 3`, using registered values only (no same-cycle pop lookahead). Otherwise `op_cen`=1.
- Address increments after each issue and wraps from DEPTH-1 to 0. After `word_cnt` issues, go to DRAIN.
- DRAIN: when the FIFO is empty, no read is in flight, and the last word has transferred, go to FIN. FIN then goes to IDLE.
- `cl_sel` = `busy` = (state != IDLE), and it is registered. `op_wen`=1 always.
- `op_q` is captured into a 3-entry FIFO in the cycle it is valid (inflight=1). FIFO head drives `out_data`/`out_valid`. Data is held stable while valid && !ready.
- `start` outside IDLE is ignored, with no error.
- Counters are ADDR_W bits; `word_cnt` > DEPTH is legal and rereads wrapped addresses.

## Timing
- Reset values: `cl_sel`=0, `busy`=0, `op_cen`=1, `op_wen`=1, `op_addr`=0, `out_valid`=0, `out_data`=0, `done`=0, `err`=0; FIFO empty, state IDLE.
- `start` at cycle 0 gives `cl_sel`=1 and the first `op_cen`=0 (addr=base) in cycle 1. `op_q` is valid in cycle 2, and `out_valid`=1 in cycle 3.
- Throughput is 1 word/cycle with `out_ready` held high. Throttling `out_ready` stalls issue after at most 3 buffered/in-flight words, with no data loss.
- Final transfer in cycle T gives `done`=1 and `cl_sel` still 1 in cycle T+1. In cycle T+2, `cl_sel`=0 and `busy`=0.
- `word_cnt`=0: `done` in cycle 1; `op_cen` never asserted.
- `reset` mid-operation: the next cycle shows the reset values above. The in-flight `op_q` is discarded; no `done` is issued.

## Structure
- Package `op_rd_pkg`: state enum (IDLE/READ/DRAIN/FIN), `OP_DEPTH`=340, `OP_ADDR_W`=9, `OP_DATA_W`=128, `FIFO_DEPTH`=3.
- Sub-module `op_rd_fifo`: 3-entry synchronous FIFO with push/pop/occupancy, no full overflow (guaranteed by credit).
- Top holds the FSM, address/issue counters, the inflight flag and the output handshake.

## Test plan
- Base 0, cnt 4, `out_ready`=1, SRAM preloaded word i = {8{i[15:0]}}. Expected: 4 transfers, data 0..3 in order, starting at cycle 3. `done` is at cycle 7 and `cl_sel` is high in cycles 1-7.
- Base 338, cnt 4. Expected: addresses 338, 339, 0, 1 are issued and data comes out in that order.
- Cnt 8 with `out_ready` toggling 1-0-0-1. Expected: no more than 3 outstanding (occupancy + inflight), no word lost or duplicated, and `out_data` stable during stalls.
- `start` with base 400. Expected: `err` pulses in cycle 1, `cl_sel` stays 0 and `op_cen` stays 1. Cnt 0 with base 5: `done` in cycle 1 and no reads.
- `reset` asserted in cycle 4 of a cnt-10 run. Expected: all outputs at reset values from cycle 5 and no `done`. A new `start` afterwards then runs correctly from its new base.
- `start` pulsed again while in READ. Expected: it is ignored, and the original run completes with the original count.
